// File: rtl/pulse_ctrl_pkg.sv
// pulse_ctrl_pkg -- shared definitions for the pulse window controller.
//   state_e        : controller state encoding
//   DRAIN_CYCLES   : cycles spent in DRAIN letting the external counter settle
//   WIN_W_DEFAULT  : default width of the window-length counter
//   is_busy()      : Busy decode for a given state
package pulse_ctrl_pkg;

  localparam int unsigned WIN_W_DEFAULT = 16;
  localparam int unsigned DRAIN_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_DRAIN,
    ST_LATCH,
    ST_DONE
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge -- two-flop synchronizer followed by a rising-edge detector.
//   CLK      : clock
//   Reset_n  : asynchronous active-low reset, clears all flops
//   Pulse_in : raw asynchronous pulse
//   Rise_out : high for one cycle when the synchronized pulse goes 0 -> 1
//              (combinational from flops; two cycles after the input rise)
module pulse_sync_edge (
  input  logic CLK,
  input  logic Reset_n,
  input  logic Pulse_in,
  output logic Rise_out
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= Pulse_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign Rise_out = sync2_q & ~prev_q;

endmodule

// File: rtl/pulse_window_ctrl.sv
// pulse_window_ctrl -- gates an external BCD pulse counter for a programmable
// window of CLK cycles and latches its result.
//   CLK, Reset_n          : clock, asynchronous active-low reset
//   Start, Window_len     : begin a measurement; window length sampled on accept
//                           (0 is treated as 1)
//   Pulse_in              : raw asynchronous pulse source
//   Units_in, Tens_in     : BCD digits from the external counter
//   Cnt_clr, Cnt_pulse    : clear / count strobes to the external counter
//   Busy                  : high outside IDLE and DONE
//   Result_valid/_ack     : result handshake
//   Units_out, Tens_out   : latched BCD result
// Build option: PULSE_WINDOW_CONTINUOUS_EN -- measurements repeat back to back
// with the captured length; Result_valid becomes a 1-cycle pulse per result.
module pulse_window_ctrl
  import pulse_ctrl_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIN_W-1:0] Window_len,
  input  logic             Pulse_in,
  input  logic [3:0]       Units_in,
  input  logic [3:0]       Tens_in,
  output logic             Cnt_clr,
  output logic             Cnt_pulse,
  output logic             Busy,
  output logic             Result_valid,
  input  logic             Result_ack,
  output logic [3:0]       Units_out,
  output logic [3:0]       Tens_out
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic             cnt_clr_q;
  logic             cnt_pulse_q;
  logic             busy_q;
  logic             result_valid_q;
  logic [3:0]       units_q;
  logic [3:0]       tens_q;
  logic             rise;

  pulse_sync_edge u_sync (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .Pulse_in (Pulse_in),
    .Rise_out (rise)
  );

  // cnt_q is shared: it counts down the window in COUNT and the settle
  // cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_CLEAR;
          len_d   = (Window_len == '0) ? WIN_W'(1) : Window_len;
        end
      end
      ST_CLEAR: begin
        state_d = ST_COUNT;
        cnt_d   = len_q - WIN_W'(1);
      end
      ST_COUNT: begin
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
          cnt_d   = WIN_W'(DRAIN_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - WIN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_LATCH;
        end else begin
          cnt_d = cnt_q - WIN_W'(1);
        end
      end
      ST_LATCH: begin
`ifdef PULSE_WINDOW_CONTINUOUS_EN
        state_d = ST_CLEAR;
`else
        state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (Result_ack) begin
          if (Start) begin
            state_d = ST_CLEAR;
            len_d   = (Window_len == '0) ? WIN_W'(1) : Window_len;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe. Cnt_pulse is registered from the current state: an
  // edge detected on the last COUNT cycle strobes during the first DRAIN
  // cycle, which DRAIN exists to absorb, while edges detected in DRAIN drop.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      cnt_clr_q      <= 1'b0;
      cnt_pulse_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      units_q        <= '0;
      tens_q         <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      cnt_clr_q   <= (state_d == ST_CLEAR);
      cnt_pulse_q <= (state_q == ST_COUNT) && rise;
      busy_q      <= is_busy(state_d);
      if (state_q == ST_LATCH) begin
        units_q <= Units_in;
        tens_q  <= Tens_in;
      end
`ifdef PULSE_WINDOW_CONTINUOUS_EN
      result_valid_q <= (state_q == ST_LATCH);
`else
      result_valid_q <= (state_d == ST_DONE);
`endif
    end
  end

  assign Cnt_clr      = cnt_clr_q;
  assign Cnt_pulse    = cnt_pulse_q;
  assign Busy         = busy_q;
  assign Result_valid = result_valid_q;
  assign Units_out    = units_q;
  assign Tens_out     = tens_q;

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// tb_pulse_window_ctrl -- self-checking bench for pulse_window_ctrl.
// A behavioural BCD counter answers Cnt_clr/Cnt_pulse. Each measurement
// pushes its expected result (derived from window length and pulse timing)
// onto a scoreboard queue, popped when Result_valid appears.
module tb_pulse_window_ctrl;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Window_len = '0;
  logic        Pulse_in = 1'b0;
  logic [3:0]  Units_in;
  logic [3:0]  Tens_in;
  logic        Cnt_clr;
  logic        Cnt_pulse;
  logic        Busy;
  logic        Result_valid;
  logic        Result_ack = 1'b0;
  logic [3:0]  Units_out;
  logic [3:0]  Tens_out;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] u;
    logic [3:0] t;
    int         strobes;
  } exp_t;
  exp_t sb[$];

  pulse_window_ctrl #(.WIN_W(16)) dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Window_len   (Window_len),
    .Pulse_in     (Pulse_in),
    .Units_in     (Units_in),
    .Tens_in      (Tens_in),
    .Cnt_clr      (Cnt_clr),
    .Cnt_pulse    (Cnt_pulse),
    .Busy         (Busy),
    .Result_valid (Result_valid),
    .Result_ack   (Result_ack),
    .Units_out    (Units_out),
    .Tens_out     (Tens_out)
  );

  always #5 CLK = ~CLK;

  // External BCD pulse counter.
  logic [3:0] m_u = '0;
  logic [3:0] m_t = '0;
  always @(posedge CLK) begin
    if (Cnt_clr) begin
      m_u <= '0;
      m_t <= '0;
    end else if (Cnt_pulse) begin
      if (m_u == 4'd9) begin
        m_u <= '0;
        m_t <= (m_t == 4'd9) ? 4'd0 : m_t + 4'd1;
      end else begin
        m_u <= m_u + 4'd1;
      end
    end
  end
  assign Units_in = m_u;
  assign Tens_in  = m_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One measurement: Start at cycle 0, pulse high at cycle c when mask[c].
  // Leaves the DUT in DONE with the result checked.
  task automatic run_window(input int len, input logic [127:0] mask,
                            input bit disturb, input bit with_ack,
                            output logic [3:0] eu, output logic [3:0] et);
    int   eff, cnt, strobes, busy_n, clr_n, valid_at;
    exp_t e;
    eff = (len == 0) ? 1 : len;
    cnt = 0;
    for (int a = 0; a < eff; a++) if (mask[a]) cnt++;
    e.u = 4'(cnt % 10);
    e.t = 4'(cnt / 10);
    e.strobes = cnt;
    sb.push_back(e);

    @(negedge CLK);
    Start      = 1'b1;
    Window_len = 16'(len);
    Pulse_in   = mask[0];
    if (with_ack) Result_ack = 1'b1;
    strobes = 0; busy_n = 0; clr_n = 0; valid_at = -1;
    for (int c = 1; c < eff + 40; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        checks++;
        if (Cnt_clr !== 1'b1) $display("FAIL clr_after_start: got %b expected 1", Cnt_clr);
        else passed++;
        if (with_ack) begin
          checks++;
          if (Result_valid !== 1'b0) $display("FAIL valid_drop_on_start_ack: got %b expected 0", Result_valid);
          else passed++;
        end
      end
      if (Cnt_clr === 1'b1) clr_n++;
      if (Busy === 1'b1) busy_n++;
      if (Cnt_pulse === 1'b1) strobes++;
      if (Result_valid === 1'b1) begin
        valid_at = c;
        break;
      end
      Start      = 1'b0;
      Result_ack = 1'b0;
      Pulse_in   = (c < 128) ? mask[c] : 1'b0;
      if (disturb && (c == 3 || c == 6)) begin
        Start      = 1'b1;
        Result_ack = 1'b1;
        Window_len = 16'(len + 7);
      end
    end
    Pulse_in = 1'b0; Start = 1'b0; Result_ack = 1'b0;

    e = sb.pop_front();
    eu = e.u;
    et = e.t;
    checks++;
    if (valid_at < 0) begin
      $display("FAIL result_timeout: no Result_valid within %0d cycles (len %0d)", eff + 40, len);
    end else if (valid_at !== eff + 5) begin
      $display("FAIL valid_latency: got cycle %0d expected %0d (len %0d)", valid_at, eff + 5, len);
    end else passed++;
    checks++;
    if (busy_n !== eff + 4) $display("FAIL busy_cycles: got %0d expected %0d (len %0d)", busy_n, eff + 4, len);
    else passed++;
    checks++;
    if (clr_n !== 1) $display("FAIL clr_count: got %0d expected 1 (len %0d)", clr_n, len);
    else passed++;
    checks++;
    if (strobes !== e.strobes) $display("FAIL strobe_count: got %0d expected %0d (len %0d)", strobes, e.strobes, len);
    else passed++;
    checks++;
    if (Units_out !== e.u || Tens_out !== e.t)
      $display("FAIL result_bcd: got %0d%0d expected %0d%0d (len %0d)", Tens_out, Units_out, e.t, e.u, len);
    else passed++;
  endtask

  // Holds DONE for a few cycles, then acknowledges.
  task automatic ack_result(input logic [3:0] eu, input logic [3:0] et);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({Result_valid, Busy, Tens_out, Units_out} !== {1'b1, 1'b0, et, eu})
        $display("FAIL done_hold: got valid=%b busy=%b res=%0d%0d expected valid=1 busy=0 res=%0d%0d",
                 Result_valid, Busy, Tens_out, Units_out, et, eu);
      else passed++;
    end
    Result_ack = 1'b1;
    @(negedge CLK);
    Result_ack = 1'b0;
    checks++;
    if ({Result_valid, Busy} !== 2'b00)
      $display("FAIL ack_to_idle: got valid=%b busy=%b expected 0 0", Result_valid, Busy);
    else passed++;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Start   = 1'b1;
    Window_len = 16'd3;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Cnt_clr, Cnt_pulse, Busy, Result_valid, Units_out, Tens_out} !== 12'h000)
      $display("FAIL reset_outputs: got clr=%b pulse=%b busy=%b valid=%b res=%0d%0d expected all 0",
               Cnt_clr, Cnt_pulse, Busy, Result_valid, Tens_out, Units_out);
    else passed++;
    Start = 1'b0;
    Reset_n = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({Busy, Cnt_clr} !== 2'b00) $display("FAIL idle_after_reset: got busy=%b clr=%b expected 0 0", Busy, Cnt_clr);
    else passed++;
  endtask

`ifdef PULSE_WINDOW_CONTINUOUS_EN
  task automatic test_continuous();
    int highs, rises, busy_n;
    logic prev;
    highs = 0; rises = 0; busy_n = 0; prev = 1'b0;
    @(negedge CLK);
    Start = 1'b1; Window_len = 16'd3; Result_ack = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Result_valid === 1'b1) highs++;
      if (Result_valid === 1'b1 && prev === 1'b0) rises++;
      if (Busy === 1'b1) busy_n++;
      prev = Result_valid;
    end
    Result_ack = 1'b0;
    checks++;
    if (highs !== 3 || rises !== 3) $display("FAIL continuous_valid: got %0d high cycles %0d pulses expected 3 3", highs, rises);
    else passed++;
    checks++;
    if (busy_n !== 22) $display("FAIL continuous_busy: got %0d expected 22", busy_n);
    else passed++;
    Reset_n = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0) $display("FAIL continuous_reset_idle: got %b expected 0", Busy);
    else passed++;
  endtask
`else
  task automatic test_main_window();
    logic [127:0] m;
    logic [3:0] u, t;
    m = '0; m[5] = 1'b1; m[15] = 1'b1; m[25] = 1'b1; m[35] = 1'b1;
    run_window(50, m, 1'b0, 1'b0, u, t);
    ack_result(u, t);
    m = '0;
    for (int i = 0; i < 12; i++) m[i*3] = 1'b1;
    run_window(40, m, 1'b0, 1'b0, u, t);
    ack_result(u, t);
  endtask

  task automatic test_zero_window();
    logic [127:0] m;
    logic [3:0] u, t;
    m = '0; m[0] = 1'b1;
    run_window(0, m, 1'b0, 1'b0, u, t);
    ack_result(u, t);
  endtask

  task automatic test_busy_ignore();
    logic [127:0] m;
    logic [3:0] u, t;
    m = '0; m[4] = 1'b1; m[8] = 1'b1; m[22] = 1'b1;
    run_window(20, m, 1'b1, 1'b0, u, t);
    ack_result(u, t);
  endtask

  task automatic test_window_edges();
    logic [127:0] m;
    logic [3:0] u, t;
    m = '0; m[2] = 1'b1; m[9] = 1'b1;
    run_window(10, m, 1'b0, 1'b0, u, t);
    ack_result(u, t);
    m = '0; m[10] = 1'b1; m[12] = 1'b1;
    run_window(10, m, 1'b0, 1'b0, u, t);
    ack_result(u, t);
  endtask

  task automatic test_back_to_back();
    logic [127:0] m;
    logic [3:0] u, t;
    m = '0; m[2] = 1'b1;
    run_window(6, m, 1'b0, 1'b0, u, t);
    m = '0; m[0] = 1'b1; m[2] = 1'b1;
    run_window(4, m, 1'b0, 1'b1, u, t);
    ack_result(u, t);
  endtask

  task automatic test_reset_mid_count();
    logic [127:0] m;
    logic [3:0] u, t;
    @(negedge CLK);
    Start = 1'b1; Window_len = 16'd30; Pulse_in = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      Pulse_in = (c == 2 || c == 4) ? 1'b1 : 1'b0;
    end
    checks++;
    if ({Busy, Cnt_pulse, Units_out} !== {1'b1, 1'b1, 4'd2})
      $display("FAIL pre_reset_state: got busy=%b pulse=%b units=%0d expected 1 1 2", Busy, Cnt_pulse, Units_out);
    else passed++;
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({Cnt_clr, Cnt_pulse, Busy, Result_valid, Units_out, Tens_out} !== 12'h000)
      $display("FAIL async_reset_outputs: got clr=%b pulse=%b busy=%b valid=%b res=%0d%0d expected all 0",
               Cnt_clr, Cnt_pulse, Busy, Result_valid, Tens_out, Units_out);
    else passed++;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Busy, Result_valid, Cnt_clr} !== 3'b000)
      $display("FAIL idle_after_midreset: got busy=%b valid=%b clr=%b expected 0 0 0", Busy, Result_valid, Cnt_clr);
    else passed++;
    m = '0; m[1] = 1'b1; m[3] = 1'b1;
    run_window(8, m, 1'b0, 1'b0, u, t);
    ack_result(u, t);
  endtask
`endif

  initial begin
    test_reset();
`ifdef PULSE_WINDOW_CONTINUOUS_EN
    test_continuous();
`else
    test_main_window();
    test_zero_window();
    test_busy_ignore();
    test_window_edges();
    test_back_to_back();
    test_reset_mid_count();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pulse_window_ctrl.md
PULSE_WINDOW_CTRL -- requirements
Module: pulse_window_ctrl

Interface
REQ-001 SHALL have parameter WIN_W, default 16: width of the window-length counter, in bits.
REQ-002 SHALL have port CLK, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port Start, input, 1 bit: one-cycle request to begin a measurement.
REQ-005 SHALL have port Window_len, input, WIN_W bits: counting window length in CLK cycles, sampled when Start is accepted.
REQ-006 SHALL have port Pulse_in, input, 1 bit: raw asynchronous pulse source.
REQ-007 SHALL have ports Units_in and Tens_in, input, 4 bits each: BCD digits returned by the pulse counter.
REQ-008 SHALL have port Cnt_clr, output, 1 bit: clear strobe to the pulse counter.
REQ-009 SHALL have port Cnt_pulse, output, 1 bit: one-cycle count strobe to the pulse counter.
REQ-010 SHALL have port Busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-011 SHALL have ports Result_valid, output, 1 bit, and Result_ack, input, 1 bit: result handshake.
REQ-012 SHALL have ports Units_out and Tens_out, output, 4 bits each: latched BCD result.

Function
REQ-013 SHALL pass Pulse_in through a 2-flop synchronizer, then a rising-edge detector.
REQ-014 SHALL assert Cnt_pulse for exactly one cycle per detected rising edge, only while in COUNT; Cnt_pulse SHALL lag the Pulse_in rise by 3 cycles.
REQ-015 SHALL implement the states IDLE, CLEAR, COUNT, DRAIN, LATCH and DONE.
REQ-016 SHALL move IDLE -> CLEAR on Start and capture Window_len at that edge.
REQ-017 SHALL stay in CLEAR for 1 cycle with Cnt_clr=1, then go to COUNT.
REQ-018 SHALL stay in COUNT for exactly the captured Window_len cycles, then go to DRAIN; a captured value of 0 SHALL be treated as 1.
REQ-019 SHALL stay in DRAIN for DRAIN_CYCLES (2) cycles with Cnt_pulse forced to 0, so the counter output settles.
REQ-020 SHALL, in LATCH, capture Units_in/Tens_in into Units_out/Tens_out in 1 cycle, then go to DONE.
REQ-021 SHALL hold Result_valid=1 and Units_out/Tens_out stable in DONE until Result_ack=1, then go to IDLE.
REQ-022 SHALL ignore Start whenever Busy=1; a Window_len change during a measurement SHALL have no effect.
REQ-023 SHALL go DONE -> CLEAR, clearing Result_valid, when Start and Result_ack are both 1 in the same cycle in DONE.
REQ-024 SHALL ignore Result_ack outside DONE.
REQ-025 SHALL count a pulse edge that lands on the last COUNT cycle and drop an edge that lands in DRAIN.

Reset
REQ-026 SHALL, on Reset_n low, go to IDLE immediately, including mid-measurement.
REQ-027 SHALL, on Reset_n low, force Cnt_clr, Cnt_pulse, Busy and Result_valid to 0, Units_out/Tens_out to 0, and the synchronizer flops and window counter to 0.
REQ-028 SHALL leave reset synchronously: the first state change occurs on the first CLK edge after Reset_n is high.

Configuration
REQ-029 SHALL, with PULSE_WINDOW_CONTINUOUS_EN defined, go LATCH -> CLEAR (not DONE) and reuse the captured Window_len.
REQ-030 SHALL, with PULSE_WINDOW_CONTINUOUS_EN defined, pulse Result_valid for 1 cycle per result, ignore Result_ack, and return to IDLE only on reset.
REQ-031 SHALL, without PULSE_WINDOW_CONTINUOUS_EN, behave as in REQ-015 to REQ-025.

Structure
REQ-032 SHALL place the state enumeration, DRAIN_CYCLES=2 and the WIN_W default in the shared package pulse_ctrl_pkg.
REQ-033 SHALL implement the synchronizer and edge detector as sub-module pulse_sync_edge, with ports CLK, Reset_n, Pulse_in and Rise_out.

Verification
REQ-034 SHALL cover: Window_len=50 with 4 clean pulses inside the window -> Cnt_clr 1 cycle after Start, 4 Cnt_pulse strobes, result latched, Result_valid held until ack.
REQ-035 SHALL cover: Window_len=0 -> COUNT lasts 1 cycle; full sequence completes, Busy=1 for 5 cycles.
REQ-036 SHALL cover: Start repeated while Busy, and Window_len changed mid-window -> no restart, original length used.
REQ-037 SHALL cover: pulse edge on the last COUNT cycle -> counted; edge in DRAIN -> not counted.
REQ-038 SHALL cover: Reset_n low during COUNT -> all outputs 0 that cycle, IDLE, then a clean next measurement.
REQ-039 SHALL cover: Start and Result_ack together in DONE -> Result_valid low next cycle, CLEAR entered; with PULSE_WINDOW_CONTINUOUS_EN, 3 back-to-back 1-cycle Result_valid pulses.
